// File: rtl/hft_pkg.sv
// Shared market-data types and constants for the UART frame path.
// Used by the frame parser, the address mux and the book handler.
package hft_pkg;

  localparam logic [7:0]  SOF_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN        = 8;

  localparam logic [7:0] OP_ADD    = 8'd0;
  localparam logic [7:0] OP_CANCEL = 8'd1;
  localparam logic [7:0] OP_TRADE  = 8'd2;

  // Frame parser FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_OP      = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } state_t;

  // Decoded market-data message
  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  op;
    logic [15:0] price;
    logic [15:0] qty;
  } md_msg_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
// Ports: clk, reset_n (async active-low), inc (count enable), cnt (value).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Reassembles 8-byte market-data frames (SOF ADDR OP PRICE_H PRICE_L QTY_H
// QTY_L CSUM) from the UART byte stream, checks XOR checksum and opcode, and
// presents one decoded message over valid/ready. Dropped frames are counted.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   rx_data, rx_valid     byte stream from the UART receiver
//   out_valid, out_ready  message handshake to the address mux
//   out_addr/op/price/qty decoded message fields
//   *_cnt                 saturating drop counters (csum, opcode, timeout, overflow)
//   busy                  high while a frame is in progress
module uart_frame_parser #(
  parameter logic [7:0]  SOF_BYTE    = hft_pkg::SOF_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned MAX_OP      = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_addr,
  output logic [7:0]       out_op,
  output logic [15:0]      out_price,
  output logic [15:0]      out_qty,
  output logic [CNT_W-1:0] csum_err_cnt,
  output logic [CNT_W-1:0] op_err_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             busy
);

  import hft_pkg::*;

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state, next_state;
  logic [7:0]       xor_q;
  logic [7:0]       addr_q;
  logic [7:0]       op_q;
  logic [1:0]       idx;
  logic [31:0]      shadow;
  logic [TMO_W-1:0] idle_cnt;
  md_msg_t          out_msg;

  logic csum_err_c, op_err_c, ovf_c, timeout_c, load_c;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and frame verdict
  always_comb begin
    next_state = state;
    csum_err_c = 1'b0;
    op_err_c   = 1'b0;
    ovf_c      = 1'b0;
    timeout_c  = 1'b0;
    load_c     = 1'b0;
    if ((state != ST_IDLE) && !rx_valid && (idle_cnt == TMO_W'(TIMEOUT_CYC - 1))) begin
      next_state = ST_IDLE;
      timeout_c  = 1'b1;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE:    if (rx_data == SOF_BYTE) next_state = ST_ADDR;
        ST_ADDR:    next_state = ST_OP;
        ST_OP:      next_state = ST_PAYLOAD;
        ST_PAYLOAD: if (idx == 2'd3) next_state = ST_CSUM;
        ST_CSUM: begin
          next_state = ST_IDLE;
          // A pending message being accepted this cycle frees the slot
          if (rx_data != xor_q)              csum_err_c = 1'b1;
          else if (op_q > 8'(MAX_OP))        op_err_c   = 1'b1;
          else if (out_valid && !out_ready)  ovf_c      = 1'b1;
          else                               load_c     = 1'b1;
        end
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  // Frame capture, running checksum and inter-byte idle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xor_q    <= '0;
      addr_q   <= '0;
      op_q     <= '0;
      idx      <= '0;
      shadow   <= '0;
      idle_cnt <= '0;
    end else begin
      if ((state == ST_IDLE) || rx_valid) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TMO_W'(1);
      end
      if (rx_valid) begin
        case (state)
          ST_IDLE: xor_q <= '0;
          ST_ADDR: begin
            addr_q <= rx_data;
            xor_q  <= xor_q ^ rx_data;
          end
          ST_OP: begin
            op_q  <= rx_data;
            xor_q <= xor_q ^ rx_data;
            idx   <= '0;
          end
          ST_PAYLOAD: begin
            shadow <= {shadow[23:0], rx_data};
            xor_q  <= xor_q ^ rx_data;
            idx    <= idx + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Output message register and handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_msg   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (next_state != ST_IDLE);
      if (load_c) begin
        out_msg.addr  <= addr_q;
        out_msg.op    <= op_q;
        out_msg.price <= shadow[31:16];
        out_msg.qty   <= shadow[15:0];
        out_valid     <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_addr  = out_msg.addr;
  assign out_op    = out_msg.op;
  assign out_price = out_msg.price;
  assign out_qty   = out_msg.qty;

  sat_counter #(.W(CNT_W)) u_csum_cnt (
    .clk(clk), .reset_n(reset_n), .inc(csum_err_c), .cnt(csum_err_cnt)
  );
  sat_counter #(.W(CNT_W)) u_op_cnt (
    .clk(clk), .reset_n(reset_n), .inc(op_err_c), .cnt(op_err_cnt)
  );
  sat_counter #(.W(CNT_W)) u_tmo_cnt (
    .clk(clk), .reset_n(reset_n), .inc(timeout_c), .cnt(timeout_cnt)
  );
  sat_counter #(.W(CNT_W)) u_ovf_cnt (
    .clk(clk), .reset_n(reset_n), .inc(ovf_c), .cnt(ovf_cnt)
  );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames, expected
// messages queued at stimulus time and compared by a separate output monitor.
module tb_uart_frame_parser;
  import hft_pkg::*;

  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_addr;
  logic [7:0]  out_op;
  logic [15:0] out_price;
  logic [15:0] out_qty;
  logic [7:0]  csum_err_cnt, op_err_cnt, timeout_cnt, ovf_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;
  md_msg_t exp_q[$];

  uart_frame_parser #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_op(out_op), .out_price(out_price), .out_qty(out_qty),
    .csum_err_cnt(csum_err_cnt), .op_err_cnt(op_err_cnt),
    .timeout_cnt(timeout_cnt), .ovf_cnt(ovf_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: held message must match queue head; pop on accept
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected: got %h%h%h%h with no message expected",
                 out_addr, out_op, out_price, out_qty);
      end else begin
        if ({out_addr, out_op, out_price, out_qty} !== exp_q[0]) begin
          errors++;
          $display("FAIL mon_msg: got %h%h%h%h expected %h",
                   out_addr, out_op, out_price, out_qty, exp_q[0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Present one byte for one cycle, then gap idle cycles; returns 1 after an edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_body(input md_msg_t m, input int gap);
    send_byte(8'hA5, gap);
    send_byte(m.addr, gap);
    send_byte(m.op, gap);
    send_byte(m.price[15:8], gap);
    send_byte(m.price[7:0], gap);
    send_byte(m.qty[15:8], gap);
    send_byte(m.qty[7:0], gap);
  endtask

  task automatic send_frame(input md_msg_t m, input logic [7:0] cs, input int gap);
    send_body(m, gap);
    send_byte(cs, 0);
  endtask

  md_msg_t m1, m2, m3, m4, m5, mbad;

  initial begin
    m1   = '{addr: 8'h01, op: 8'h00, price: 16'h1234, qty: 16'h0064}; // csum 43
    mbad = '{addr: 8'h02, op: 8'h05, price: 16'h0010, qty: 16'h0001}; // csum 16
    m2   = '{addr: 8'h03, op: 8'h01, price: 16'h0005, qty: 16'h0002}; // csum 05
    m3   = '{addr: 8'h07, op: 8'h02, price: 16'hABCD, qty: 16'h0010}; // csum 73
    m4   = '{addr: 8'h22, op: 8'h02, price: 16'h0300, qty: 16'h0004}; // csum 27
    m5   = '{addr: 8'h10, op: 8'h01, price: 16'h0100, qty: 16'h0200}; // csum 12

    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_msg", {out_addr, out_op, out_price}, 32'd0);
    chk("rst_cnts", {csum_err_cnt, op_err_cnt, timeout_cnt, ovf_cnt}, 32'd0);

    // Good frame, 16-cycle byte spacing, one-edge latency, single pulse
    exp_q.push_back(m1);
    send_body(m1, 15);
    chk("good_pre_valid", 32'(out_valid), 32'd0);
    chk("good_busy", 32'(busy), 32'd1);
    send_byte(8'h43, 0);
    chk("good_valid_rise", 32'(out_valid), 32'd1);
    chk("good_qty", 32'(out_qty), 32'h0064);
    @(posedge clk); #1;
    chk("good_valid_fall", 32'(out_valid), 32'd0);
    chk("good_cnts", {csum_err_cnt, op_err_cnt, timeout_cnt, ovf_cnt}, 32'd0);
    repeat (3) @(posedge clk); #1;

    // Bad checksum, then a good frame
    send_frame(m1, 8'h44, 2);
    chk("badcs_valid", 32'(out_valid), 32'd0);
    chk("badcs_cnt", 32'(csum_err_cnt), 32'd1);
    exp_q.push_back(m1);
    send_frame(m1, 8'h43, 2);
    chk("badcs_next_valid", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk); #1;

    // Bad opcode with correct checksum
    send_frame(mbad, 8'h16, 2);
    chk("badop_valid", 32'(out_valid), 32'd0);
    chk("badop_cnt", 32'(op_err_cnt), 32'd1);
    chk("badop_csum_cnt", 32'(csum_err_cnt), 32'd1);
    repeat (3) @(posedge clk); #1;

    // Inter-byte timeout, then resync after junk bytes
    send_byte(8'hA5, 2);
    send_byte(8'h01, 2);
    send_byte(8'h00, 0);
    repeat (40) @(posedge clk); #1;
    chk("tmo_busy_hold", 32'(busy), 32'd1);
    chk("tmo_cnt_hold", 32'(timeout_cnt), 32'd0);
    repeat (40) @(posedge clk); #1;
    chk("tmo_busy_fall", 32'(busy), 32'd0);
    chk("tmo_cnt", 32'(timeout_cnt), 32'd1);
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    chk("junk_busy", 32'(busy), 32'd0);
    exp_q.push_back(m5);
    send_frame(m5, 8'h12, 2);
    chk("resync_valid", 32'(out_valid), 32'd1);
    chk("resync_price", 32'(out_price), 32'h0100);
    repeat (3) @(posedge clk); #1;

    // Backpressure: overflow drop, then same-cycle accept and reload
    out_ready = 1'b0;
    exp_q.push_back(m1);
    send_frame(m1, 8'h43, 3);
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    repeat (5) @(posedge clk); #1;
    send_frame(m2, 8'h05, 3);
    chk("bp_ovf", 32'(ovf_cnt), 32'd1);
    chk("bp_held_addr", 32'(out_addr), 32'h01);
    exp_q.push_back(m3);
    send_body(m3, 3);
    out_ready = 1'b1;
    send_byte(8'h73, 0);
    chk("bp_reload_valid", 32'(out_valid), 32'd1);
    chk("bp_reload_addr", 32'(out_addr), 32'h07);
    chk("bp_ovf_hold", 32'(ovf_cnt), 32'd1);
    @(posedge clk); #1;
    chk("bp_final_fall", 32'(out_valid), 32'd0);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-PAYLOAD with a pending message
    out_ready = 1'b0;
    exp_q.push_back(m4);
    send_frame(m4, 8'h27, 2);
    send_byte(8'hA5, 2);
    send_byte(8'h33, 2);
    send_byte(8'h01, 2);
    send_byte(8'h11, 2);
    chk("midframe_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_msg", {out_addr, out_op, out_price}, 32'd0);
    chk("arst_cnts", {csum_err_cnt, op_err_cnt, timeout_cnt, ovf_cnt}, 32'd0);
    repeat (2) @(posedge clk); #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Counter saturation
    for (int i = 0; i < 255; i++) send_frame(m1, 8'h44, 0);
    chk("sat_255", 32'(csum_err_cnt), 32'hFF);
    for (int i = 0; i < 45; i++) send_frame(m1, 8'h44, 0);
    chk("sat_300", 32'(csum_err_cnt), 32'hFF);
    chk("sat_valid", 32'(out_valid), 32'd0);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
